maxnet_sequencer: RTL

Sequential controller that runs a 4-neuron Maxnet competition to completion. It captures four candidate scores, then iterates the lateral-inhibition update `x_i ← max(0, x_i − ε·Σ_{j≠i} x_j)`. After every iteration it applies the exactly-one-survivor termination test. It reports the winning index and value, or flags a tie/timeout. It sits between the scoring layer and downstream consumers, replacing the free-running combinational termination check with a bounded, handshaked sequence.

---
 rtl/maxnet_pkg.sv | 29 ++
 rtl/maxnet_update.sv | 33 +++
 rtl/maxnet_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the 4-neuron Maxnet sequencer.
package maxnet_pkg;

  localparam int unsigned NEURONS       = 4;
  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_EPS_SHIFT = 3;
  localparam int unsigned DEF_MAX_ITER  = 64;
  localparam int unsigned DEF_ITER_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One-hot to index encoder; a non-one-hot input maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NEURONS-1:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/maxnet_update.sv
// One lateral-inhibition step: x_i <- max(0, x_i - (sum_{j!=i} x_j >>> EPS_SHIFT)).
module maxnet_update
  import maxnet_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EPS_SHIFT = DEF_EPS_SHIFT
) (
  input  logic [NEURONS-1:0][WIDTH-1:0] vals,
  output logic [NEURONS-1:0][WIDTH-1:0] next_vals
);

  localparam int unsigned SW = WIDTH + 2;

  logic signed [SW-1:0] ext    [NEURONS];
  logic signed [SW-1:0] others [NEURONS];
  logic signed [SW-1:0] diff   [NEURONS];
  logic signed [SW-1:0] total;

  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < NEURONS; i++) begin
      ext[i] = {{2{vals[i][WIDTH-1]}}, vals[i]};
      total  = total + ext[i];
    end
    for (int unsigned i = 0; i < NEURONS; i++) begin
      others[i] = total - ext[i];
      diff[i]   = ext[i] - (others[i] >>> EPS_SHIFT);
      // diff never exceeds the old value, so the low WIDTH bits are exact when positive
      next_vals[i] = (diff[i] > 0) ? diff[i][WIDTH-1:0] : '0;
    end
  end

endmodule

// File: rtl/maxnet_sequencer.sv
// Bounded, handshaked Maxnet competition: capture, iterate inhibition, report survivor.
module maxnet_sequencer
  import maxnet_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EPS_SHIFT = DEF_EPS_SHIFT,
  parameter int unsigned MAX_ITER  = DEF_MAX_ITER,
  parameter int unsigned ITER_W    = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  x2,
  input  logic [WIDTH-1:0]  x3,
  input  logic [WIDTH-1:0]  x4,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner_idx,
  output logic [WIDTH-1:0]  winner_val,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  state_t                         state_q, state_d;
  logic [NEURONS-1:0][WIDTH-1:0]  vals_q, vals_d, upd, xin;
  logic [NEURONS-1:0]             active;
  logic [ITER_W-1:0]              iter_q, iter_d;
  logic [1:0]                     widx_q, widx_d;
  logic [WIDTH-1:0]               wval_q, wval_d;
  logic                           nw_q, nw_d, to_q, to_d;

  maxnet_update #(
    .WIDTH     (WIDTH),
    .EPS_SHIFT (EPS_SHIFT)
  ) u_update (
    .vals      (vals_q),
    .next_vals (upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vals_q  <= '0;
      iter_q  <= '0;
      widx_q  <= '0;
      wval_q  <= '0;
      nw_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vals_q  <= vals_d;
      iter_q  <= iter_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
      nw_q    <= nw_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vals_d  = vals_q;
    iter_d  = iter_q;
    widx_d  = widx_q;
    wval_d  = wval_q;
    nw_d    = nw_q;
    to_d    = to_q;
    xin     = {x4, x3, x2, x1};
    for (int unsigned i = 0; i < NEURONS; i++)
      active[i] = ($signed(vals_q[i]) > 0);

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < NEURONS; i++)
            vals_d[i] = xin[i][WIDTH-1] ? '0 : xin[i];
          iter_d  = '0;
          widx_d  = '0;
          wval_d  = '0;
          nw_d    = 1'b0;
          to_d    = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Survivor test outranks the iteration limit
        if ($countones(active) == 1) begin
          widx_d  = onehot_to_idx(active);
          wval_d  = vals_q[onehot_to_idx(active)];
          state_d = DONE;
        end else if (active == '0) begin
          nw_d    = 1'b1;
          state_d = DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          nw_d    = 1'b1;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        vals_d  = upd;
        iter_d  = iter_q + ITER_W'(1);
        state_d = CHECK;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy       = (state_q == CHECK) || (state_q == ITER);
    done       = (state_q == DONE);
    winner_idx = widx_q;
    winner_val = wval_q;
    no_winner  = nw_q;
    timeout    = to_q;
    iter_count = iter_q;
  end

endmodule
